mem_bus_arbiter: RTL and testbench

// - Shares the single-port program/data RAM between the CPU control path (fetch, stack, MOV)
//   and the program loader/IO port.
// - Arbitrates requests, sequences the RAM access with a fixed wait-state count, and returns a
//   one-cycle ready pulse with captured read data to the winning requester.
// - The CPU's bus_ready input is driven from cpu_ready.

---
 rtl/mem_bus_arb_pkg.sv | 17 +
 rtl/arb_pick2.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arb_pkg.sv
// Shared types for the program/data RAM arbiter.
//   arb_state_t : access sequencer states (IDLE -> ACCESS -> DONE -> IDLE)
//   owner_t     : which requester holds the bus (OWN_CPU=0, OWN_LDR=1)
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way grant picker.
// Ports:
//   req[1:0]   in  request vector, bit 0 = CPU, bit 1 = loader
//   lock       in  CPU lock (multi-access ops keep the CPU in front)
//   prio_cpu   in  1: CPU always wins a contest; 0: round-robin
//   last_owner in  owner of the previous completed access
//   owner      out chosen requester (only meaningful when req != 0)
module arb_pick2
    import mem_bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       prio_cpu,
    input  owner_t     last_owner,
    output owner_t     owner
);

    always_comb begin
        owner = OWN_CPU;
        if (req == 2'b10) begin
            // Lone loader always wins, even if the CPU holds lock.
            owner = OWN_LDR;
        end else if (req == 2'b11 && !lock && !prio_cpu && last_owner == OWN_CPU) begin
            // Contested, no CPU preference: alternate away from the last owner.
            owner = OWN_LDR;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port program/data RAM between the CPU control path and
// the program loader/IO port. A winner is picked in IDLE, its request is
// latched, the RAM is held for WAIT_STATES+1 ACCESS cycles, and a one-cycle
// ready pulse (with captured read data) is returned in DONE.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   cpu_req/we/lock/addr/wdata         CPU request side
//   cpu_rdata, cpu_ready               CPU response (rdata valid with ready)
//   ldr_req/we/addr/wdata              loader request side
//   ldr_rdata, ldr_ready               loader response
//   mem_addr/wdata/we/re, mem_rdata    RAM port
//   owner, busy                        current grant and activity status
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 2,
    parameter bit PRIO_CPU    = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    localparam logic [2:0] WS_LAST = 3'(WAIT_STATES);

    arb_state_t        state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    owner_t            own_q, own_nx, last_q, last_nx, pick;
    logic              we_q, we_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic [DATA_W-1:0] cpu_rdata_nx, ldr_rdata_nx;
    logic              mem_we_nx, mem_re_nx, busy_nx, cpu_ready_nx, ldr_ready_nx;

    arb_pick2 u_pick (
        .req        ({ldr_req, cpu_req}),
        .lock       (cpu_lock),
        .prio_cpu   (PRIO_CPU),
        .last_owner (last_q),
        .owner      (pick)
    );

    // Next-state and next-output logic; every output is registered so the
    // RAM strobes change only on clock edges (or on reset).
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        own_nx       = own_q;
        last_nx      = last_q;
        we_nx        = we_q;
        addr_nx      = addr_q;
        wdata_nx     = wdata_q;
        cpu_rdata_nx = cpu_rdata;
        ldr_rdata_nx = ldr_rdata;
        mem_we_nx    = 1'b0;
        mem_re_nx    = 1'b0;
        busy_nx      = 1'b0;
        cpu_ready_nx = 1'b0;
        ldr_ready_nx = 1'b0;

        unique case (state)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    own_nx    = pick;
                    we_nx     = (pick == OWN_LDR) ? ldr_we    : cpu_we;
                    addr_nx   = (pick == OWN_LDR) ? ldr_addr  : cpu_addr;
                    wdata_nx  = (pick == OWN_LDR) ? ldr_wdata : cpu_wdata;
                    // Write strobe is a single pulse on the first ACCESS cycle.
                    mem_we_nx = we_nx;
                    mem_re_nx = !we_nx;
                    busy_nx   = 1'b1;
                    cnt_nx    = 3'd0;
                    state_nx  = ACCESS;
                end
            end
            ACCESS: begin
                busy_nx = 1'b1;
                if (cnt == WS_LAST) begin
                    // Read data is valid now; capture it for the owner only.
                    if (!we_q) begin
                        if (own_q == OWN_LDR) ldr_rdata_nx = mem_rdata;
                        else                  cpu_rdata_nx = mem_rdata;
                    end
                    ldr_ready_nx = (own_q == OWN_LDR);
                    cpu_ready_nx = (own_q == OWN_CPU);
                    state_nx     = DONE;
                end else begin
                    cnt_nx    = cnt + 3'd1;
                    mem_re_nx = !we_q;
                end
            end
            DONE: begin
                last_nx  = own_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            own_q     <= OWN_CPU;
            last_q    <= OWN_LDR;   // CPU wins the first contest
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            cpu_ready <= 1'b0;
            ldr_ready <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            own_q     <= own_nx;
            last_q    <= last_nx;
            we_q      <= we_nx;
            addr_q    <= addr_nx;
            wdata_q   <= wdata_nx;
            cpu_rdata <= cpu_rdata_nx;
            ldr_rdata <= ldr_rdata_nx;
            mem_we    <= mem_we_nx;
            mem_re    <= mem_re_nx;
            busy      <= busy_nx;
            cpu_ready <= cpu_ready_nx;
            ldr_ready <= ldr_ready_nx;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign owner     = own_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: one WAIT_STATES=2 round-robin
// instance driven by a vector table plus corner sequences, and one
// WAIT_STATES=0 CPU-priority instance for the zero-wait build.
module tb_mem_bus_arbiter;

    localparam int WS = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- main DUT (WS=2, round-robin) ----------------
    logic       cpu_req, cpu_we, cpu_lock, ldr_req, ldr_we;
    logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic [7:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
    logic       cpu_ready, ldr_ready, mem_we, mem_re, owner, busy;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(WS), .PRIO_CPU(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    // ---------------- zero-wait DUT (WS=0, CPU priority) ----------------
    logic       z_cpu_req, z_ldr_req;
    logic [7:0] z_cpu_rdata, z_ldr_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;
    logic       z_cpu_ready, z_ldr_ready, z_mem_we, z_mem_re, z_owner, z_busy;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0), .PRIO_CPU(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(z_cpu_req), .cpu_we(1'b0), .cpu_lock(1'b0), .cpu_addr(8'h10),
        .cpu_wdata(8'h00), .cpu_rdata(z_cpu_rdata), .cpu_ready(z_cpu_ready),
        .ldr_req(z_ldr_req), .ldr_we(1'b0), .ldr_addr(8'h11), .ldr_wdata(8'h00),
        .ldr_rdata(z_ldr_rdata), .ldr_ready(z_ldr_ready),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_we(z_mem_we), .mem_re(z_mem_re),
        .mem_rdata(z_mem_rdata), .owner(z_owner), .busy(z_busy)
    );

    // ---------------- RAM models ----------------
    // Unwritten locations read as addr ^ 0xB5 (so 0x10 -> 0xA5).
    logic         ram_clr;
    logic [7:0]   ram [256];
    logic [255:0] wr_v;
    logic [7:0]   pipe0, pipe1;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'hB5;
    endfunction

    function logic [7:0] rd(input logic [7:0] a);
        return wr_v[a] ? ram[a] : init_val(a);
    endfunction

    // Read data appears WS=2 edges after the address, as a real wait-state RAM.
    always @(posedge clk) begin
        if (ram_clr) wr_v <= '0;
        else if (mem_we) begin
            ram[mem_addr]  <= mem_wdata;
            wr_v[mem_addr] <= 1'b1;
        end
        pipe0 <= rd(mem_addr);
        pipe1 <= pipe0;
    end
    assign mem_rdata   = pipe1;
    assign z_mem_rdata = init_val(z_mem_addr);

    // ---------------- checking ----------------
    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        bit         who;     // 0 = CPU, 1 = loader
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;  // requester's rdata at ready (unchanged for writes)
    } vec_t;

    // One isolated transaction: drive in IDLE, wait for the ready pulse.
    task automatic run_xact(input vec_t v, input string nm);
        int lat, wes;
        bit got, other;
        @(negedge clk);
        if (v.who) begin
            ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wdata; ldr_req = 1'b1;
        end else begin
            cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req = 1'b1;
        end
        got = 1'b0; other = 1'b0; wes = 0; lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk); @(negedge clk);
            wes += int'(mem_we);
            if (v.who ? cpu_ready : ldr_ready) other = 1'b1;
            if (v.who ? ldr_ready : cpu_ready) begin got = 1'b1; lat = i; end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        check({nm, " latency"}, 64'(lat), 64'(WS + 2));
        check({nm, " rdata"}, 64'(v.who ? ldr_rdata : cpu_rdata), 64'(v.exp_rd));
        check({nm, " other_ready"}, 64'(other), 64'd0);
        check({nm, " we_pulses"}, 64'(wes), 64'(v.we ? 1 : 0));
    endtask

    // Both requesters held; record the owner of each of n grants (bit i = grant i)
    // and count grants whose spacing is not WS+3 cycles.
    task automatic grants(input int n, input int unlock_after,
                          output logic [7:0] own, output int bad_gap, output int got);
        int last_t;
        own = '0; bad_gap = 0; got = 0; last_t = -1;
        @(negedge clk);
        cpu_we = 1'b0; ldr_we = 1'b0; cpu_addr = 8'h10; ldr_addr = 8'h11;
        cpu_req = 1'b1; ldr_req = 1'b1;
        for (int t = 0; t < 60 && got < n; t++) begin
            @(posedge clk); @(negedge clk);
            if (cpu_ready || ldr_ready) begin
                own[got] = ldr_ready;
                if (last_t >= 0 && t - last_t != WS + 3) bad_gap++;
                last_t = t;
                got++;
                if (got == unlock_after) cpu_lock = 1'b0;
            end
        end
        cpu_req = 1'b0; ldr_req = 1'b0; cpu_lock = 1'b0;
    endtask

    vec_t       vecs [7];
    logic [7:0] own;
    int         bad_gap, got, wes, lat;
    bit         seen;

    initial begin
        vecs[0] = '{who: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rd: 8'hA5};
        vecs[1] = '{who: 1'b1, we: 1'b1, addr: 8'h30, wdata: 8'h5E, exp_rd: 8'h00};
        vecs[2] = '{who: 1'b0, we: 1'b0, addr: 8'h30, wdata: 8'h00, exp_rd: 8'h5E};
        vecs[3] = '{who: 1'b1, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rd: 8'hA5};
        vecs[4] = '{who: 1'b0, we: 1'b1, addr: 8'h10, wdata: 8'h77, exp_rd: 8'h5E};
        vecs[5] = '{who: 1'b1, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rd: 8'h77};
        vecs[6] = '{who: 1'b0, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rd: 8'h4A};

        reset_n = 1'b0; ram_clr = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        z_cpu_req = 1'b0; z_ldr_req = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outputs", {cpu_rdata, ldr_rdata, mem_addr, mem_wdata,
                                cpu_ready, ldr_ready, mem_we, mem_re, owner, busy}, 64'd0);
        check("reset outputs ws0", {z_cpu_rdata, z_ldr_rdata, z_mem_addr, z_mem_wdata,
                                    z_cpu_ready, z_ldr_ready, z_mem_we, z_mem_re, z_owner,
                                    z_busy}, 64'd0);
        reset_n = 1'b1; ram_clr = 1'b0;

        // Isolated transactions from the vector table.
        foreach (vecs[i]) run_xact(vecs[i], $sformatf("vec%0d", i));

        // Round-robin from reset: CPU, LDR, CPU, LDR, one every WS+3 cycles.
        @(negedge clk); reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
        grants(4, 99, own, bad_gap, got);
        check("rr grants", 64'(got), 64'd4);
        check("rr order", 64'(own[3:0]), 64'b1010);
        check("rr spacing", 64'(bad_gap), 64'd0);

        // Lock: CPU wins three contests, loader gets the one after unlock.
        cpu_lock = 1'b1;
        grants(4, 3, own, bad_gap, got);
        check("lock grants", 64'(got), 64'd4);
        check("lock order", 64'(own[3:0]), 64'b1000);

        // Loader write, request dropped on the first ACCESS cycle.
        @(negedge clk);
        ldr_we = 1'b1; ldr_addr = 8'h20; ldr_wdata = 8'h3C; ldr_req = 1'b1;
        @(posedge clk); @(negedge clk);
        ldr_req = 1'b0;
        wes = int'(mem_we); seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            wes += int'(mem_we);
            if (ldr_ready) seen = 1'b1;
        end
        ldr_we = 1'b0;
        check("drop ldr_ready", 64'(seen), 64'd1);
        check("drop we_pulses", 64'(wes), 64'd1);
        run_xact('{who: 1'b0, we: 1'b0, addr: 8'h20, wdata: 8'h00, exp_rd: 8'h3C}, "readback");

        // Asynchronous reset in the middle of a write access.
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'h11; cpu_req = 1'b1;
        @(posedge clk); @(negedge clk);
        check("pre-reset we/busy", {mem_we, busy}, 64'b11);
        #2 reset_n = 1'b0;
        #1 check("async reset we/re/busy", {mem_we, mem_re, busy}, 64'd0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        run_xact('{who: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rd: 8'h77}, "post-reset");

        // Zero-wait build: 2-cycle read latency, then CPU priority under contention.
        @(negedge clk); reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
        @(negedge clk); z_cpu_req = 1'b1;
        seen = 1'b0; lat = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            if (z_cpu_ready) begin seen = 1'b1; lat = i; end
        end
        z_cpu_req = 1'b0;
        check("ws0 latency", 64'(lat), 64'd2);
        check("ws0 rdata", 64'(z_cpu_rdata), 64'hA5);

        @(negedge clk); z_cpu_req = 1'b1; z_ldr_req = 1'b1;
        got = 0; own = '0;
        for (int t = 0; t < 20 && got < 2; t++) begin
            @(posedge clk); @(negedge clk);
            if (z_cpu_ready || z_ldr_ready) begin own[got] = z_ldr_ready; got++; end
        end
        z_cpu_req = 1'b0; z_ldr_req = 1'b0;
        check("prio grants", 64'(got), 64'd2);
        check("prio order", 64'(own[1:0]), 64'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
